// File: rtl/serdesphy_rx_pkg.sv
// Shared receive-path definitions: line state encoding and the idle fill byte.
package serdesphy_rx_pkg;

  typedef enum logic [1:0] {
    RX_OFF  = 2'b00,
    RX_DATA = 2'b01,
    RX_IDLE = 2'b10
  } rx_state_e;

  localparam int          BYTE_W     = 8;
  localparam int          SKID_DEPTH = 2;
  localparam logic [7:0]  IDLE_BYTE  = 8'h00;

endpackage

// File: rtl/serdesphy_rx_skid_buf.sv
// Two-entry in-order buffer between the demux and the RX FIFO write port.
// The caller only pushes when there is room (or a pop frees a slot in the same
// cycle) and only pops when not empty.
module serdesphy_rx_skid_buf
  import serdesphy_rx_pkg::*;
#(
  parameter int W = BYTE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [SKID_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  assign full  = (count == 2'(SKID_DEPTH));
  assign empty = (count == 2'd0);
  // Present zero when empty so the FIFO port never shows stale or unknown data.
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage write. When full, push and pop together write into the slot being
  // vacated, which is safe because the head is read out in the same cycle.
  // NOTE: storage has no reset; head_data is masked while empty, so the
  // contents are never observed before being written.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/serdesphy_rx_data_demux.sv
// Routes decoded bytes to the RX FIFO (through a 2-entry buffer) or to the PRBS
// checker, tracks line idle (runs of 0x00) and counts bytes lost to FIFO
// back-pressure. The decoder is never stalled.
module serdesphy_rx_data_demux
  import serdesphy_rx_pkg::*;
#(
  parameter int IDLE_THRESH = 4,
  parameter int DROP_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              rx_data_sel,
  input  logic              drop_clr,
  input  logic [7:0]        dec_data,
  input  logic              dec_valid,
  output logic [7:0]        fifo_data,
  output logic              fifo_valid,
  input  logic              fifo_ready,
  output logic [7:0]        chk_data,
  output logic              chk_valid,
  output logic              rx_idle_det,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [3:0] THRESH    = 4'(IDLE_THRESH);
  localparam logic [3:0] THRESH_M1 = 4'(IDLE_THRESH - 1);

  rx_state_e  state;
  rx_state_e  state_nxt;
  logic [3:0] zero_cnt;
  logic       byte_zero;
  logic       push_req;
  logic       push;
  logic       pop;
  logic       drop;
  logic       buf_full;
  logic       buf_empty;

  assign byte_zero   = (dec_data == IDLE_BYTE);
  assign rx_idle_det = (state == RX_IDLE);
  assign fifo_valid  = !buf_empty;
  assign pop         = fifo_valid && fifo_ready;
  assign push        = push_req && (!buf_full || pop);
  assign drop        = push_req && buf_full && !pop;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_OFF;
    else        state <= state_nxt;
  end

  // Next-state and FIFO push request; bytes seen while OFF are ignored.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    if (!enable) begin
      state_nxt = RX_OFF;
    end else begin
      case (state)
        RX_OFF: state_nxt = RX_DATA;
        RX_DATA: begin
          if (dec_valid) begin
            if (byte_zero && zero_cnt == THRESH_M1) state_nxt = RX_IDLE;
            else                                    push_req  = !rx_data_sel;
          end
        end
        RX_IDLE: begin
          if (dec_valid && !byte_zero) begin
            state_nxt = RX_DATA;
            push_req  = !rx_data_sel;
          end
        end
        default: state_nxt = RX_OFF;
      endcase
    end
  end

  // Zero-run counter, saturating at the idle threshold, in both routing modes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt <= 4'd0;
    end else if (!enable) begin
      zero_cnt <= 4'd0;
    end else if (state != RX_OFF && dec_valid) begin
      if (!byte_zero)              zero_cnt <= 4'd0;
      else if (zero_cnt != THRESH) zero_cnt <= zero_cnt + 4'd1;
    end
  end

  // Saturating drop counter; a clear coinciding with a drop leaves a count of 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (!enable) begin
      drop_cnt <= '0;
    end else if (drop_clr) begin
      drop_cnt <= drop ? DROP_W'(1) : '0;
    end else if (drop && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  // One-cycle strobe of each byte routed to the PRBS checker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_valid <= 1'b0;
      chk_data  <= 8'h00;
    end else if (!enable) begin
      chk_valid <= 1'b0;
      chk_data  <= 8'h00;
    end else begin
      chk_valid <= dec_valid && rx_data_sel && (state != RX_OFF);
      if (dec_valid && rx_data_sel && state != RX_OFF) chk_data <= dec_data;
    end
  end

  serdesphy_rx_skid_buf #(.W(BYTE_W)) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (!enable),
    .push      (push),
    .push_data (dec_data),
    .pop       (pop),
    .head_data (fifo_data),
    .full      (buf_full),
    .empty     (buf_empty)
  );

endmodule

// File: tb/tb_serdesphy_rx_data_demux.sv
// Directed testbench for serdesphy_rx_data_demux (IDLE_THRESH=4, DROP_W=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_serdesphy_rx_data_demux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       rx_data_sel = 1'b0;
  logic       drop_clr = 1'b0;
  logic [7:0] dec_data = 8'h00;
  logic       dec_valid = 1'b0;
  logic [7:0] fifo_data;
  logic       fifo_valid;
  logic       fifo_ready = 1'b0;
  logic [7:0] chk_data;
  logic       chk_valid;
  logic       rx_idle_det;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  serdesphy_rx_data_demux #(.IDLE_THRESH(4), .DROP_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .rx_data_sel (rx_data_sel),
    .drop_clr    (drop_clr),
    .dec_data    (dec_data),
    .dec_valid   (dec_valid),
    .fifo_data   (fifo_data),
    .fifo_valid  (fifo_valid),
    .fifo_ready  (fifo_ready),
    .chk_data    (chk_data),
    .chk_valid   (chk_valid),
    .rx_idle_det (rx_idle_det),
    .drop_cnt    (drop_cnt)
  );

  // Roughly 24 MHz.
  always #21 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  // One clock cycle, optionally with a decoded byte; drop_clr is a one-cycle pulse.
  task automatic step(input logic v, input logic [7:0] d);
    dec_valid = v;
    dec_data  = d;
    @(posedge clk);
    #1;
    dec_valid = 1'b0;
    drop_clr  = 1'b0;
  endtask

  task automatic test_reset();
    #5;
    checks++; if ({fifo_valid, chk_valid, rx_idle_det} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {fifo_valid, chk_valid, rx_idle_det}); end
    checks++; if ({fifo_data, chk_data, drop_cnt} !== 24'h0) begin errors++; $display("FAIL reset_data: got %h want 000000", {fifo_data, chk_data, drop_cnt}); end
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    enable = 1'b1;
    step(1'b0, 8'h00);
    checks++; if ({fifo_valid, chk_valid, rx_idle_det, drop_cnt} !== 11'h0) begin errors++; $display("FAIL post_reset: got %h want 0", {fifo_valid, chk_valid, rx_idle_det, drop_cnt}); end
  endtask

  task automatic test_fifo_basic();
    rx_data_sel = 1'b0;
    fifo_ready  = 1'b1;
    step(1'b1, 8'hA5);
    checks++; if (fifo_valid !== 1'b1 || fifo_data !== 8'hA5) begin errors++; $display("FAIL basic_a5: got v=%b d=%h want v=1 d=a5", fifo_valid, fifo_data); end
    step(1'b1, 8'h3C);
    checks++; if (fifo_valid !== 1'b1 || fifo_data !== 8'h3C) begin errors++; $display("FAIL basic_3c: got v=%b d=%h want v=1 d=3c", fifo_valid, fifo_data); end
    step(1'b0, 8'h00);
    checks++; if (fifo_valid !== 1'b0 || drop_cnt !== 8'd0 || chk_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got v=%b drop=%0d chk=%b want 0 0 0", fifo_valid, drop_cnt, chk_valid); end
  endtask

  task automatic test_idle();
    int fwd_zeros = 0;
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 8'h00);
      if (fifo_valid === 1'b1 && fifo_data === 8'h00) fwd_zeros++;
      checks++; if (rx_idle_det !== 1'b0) begin errors++; $display("FAIL idle_early_%0d: got %b want 0", k, rx_idle_det); end
    end
    step(1'b1, 8'h00);
    checks++; if (rx_idle_det !== 1'b1 || fifo_valid !== 1'b0) begin errors++; $display("FAIL idle_enter: got idle=%b v=%b want idle=1 v=0", rx_idle_det, fifo_valid); end
    for (int k = 5; k <= 6; k++) begin
      step(1'b1, 8'h00);
      checks++; if (rx_idle_det !== 1'b1 || fifo_valid !== 1'b0) begin errors++; $display("FAIL idle_hold_%0d: got idle=%b v=%b want idle=1 v=0", k, rx_idle_det, fifo_valid); end
    end
    checks++; if (fwd_zeros != 3) begin errors++; $display("FAIL idle_fwd_zeros: got %0d want 3", fwd_zeros); end
    step(1'b1, 8'h5A);
    checks++; if (rx_idle_det !== 1'b0 || fifo_valid !== 1'b1 || fifo_data !== 8'h5A) begin errors++; $display("FAIL idle_exit: got idle=%b v=%b d=%h want 0 1 5a", rx_idle_det, fifo_valid, fifo_data); end
    step(1'b0, 8'h00);
  endtask

  task automatic test_prbs();
    logic [7:0] pat [3];
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h00;
    rx_data_sel = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, pat[k]);
      checks++; if (chk_valid !== 1'b1 || chk_data !== pat[k] || fifo_valid !== 1'b0) begin errors++; $display("FAIL prbs_%0d: got chk=%b d=%h fv=%b want 1 %h 0", k, chk_valid, chk_data, fifo_valid, pat[k]); end
    end
    step(1'b0, 8'h00);
    checks++; if (chk_valid !== 1'b0 || fifo_valid !== 1'b0) begin errors++; $display("FAIL prbs_strobe_end: got chk=%b fv=%b want 0 0", chk_valid, fifo_valid); end
  endtask

  task automatic test_backpressure();
    rx_data_sel = 1'b0;
    fifo_ready  = 1'b0;
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    step(1'b1, 8'h44);
    step(1'b1, 8'h55);
    checks++; if (drop_cnt !== 8'd3 || fifo_valid !== 1'b1 || fifo_data !== 8'h11) begin errors++; $display("FAIL bp_full: got drop=%0d v=%b d=%h want 3 1 11", drop_cnt, fifo_valid, fifo_data); end
    drop_clr = 1'b1;
    step(1'b1, 8'h66);
    checks++; if (drop_cnt !== 8'd1 || fifo_data !== 8'h11) begin errors++; $display("FAIL bp_clr_drop: got drop=%0d d=%h want 1 11", drop_cnt, fifo_data); end
  endtask

  task automatic test_mode_switch();
    rx_data_sel = 1'b1;
    fifo_ready  = 1'b1;
    step(1'b1, 8'h77);
    checks++; if (fifo_valid !== 1'b1 || fifo_data !== 8'h22 || chk_valid !== 1'b1 || chk_data !== 8'h77) begin errors++; $display("FAIL switch_1: got fv=%b fd=%h cv=%b cd=%h want 1 22 1 77", fifo_valid, fifo_data, chk_valid, chk_data); end
    step(1'b1, 8'h88);
    checks++; if (fifo_valid !== 1'b0 || chk_valid !== 1'b1 || chk_data !== 8'h88) begin errors++; $display("FAIL switch_2: got fv=%b cv=%b cd=%h want 0 1 88", fifo_valid, chk_valid, chk_data); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL switch_drop: got %0d want 1", drop_cnt); end
  endtask

  task automatic test_drop_saturate();
    rx_data_sel = 1'b0;
    fifo_ready  = 1'b0;
    drop_clr    = 1'b1;
    step(1'b0, 8'h00);
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL sat_clr: got %0d want 0", drop_cnt); end
    for (int k = 0; k < 260; k++) step(1'b1, 8'hC3);
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_value: got %0d want 255", drop_cnt); end
  endtask

  task automatic test_enable_clear();
    drop_clr = 1'b1;
    step(1'b0, 8'h00);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h03);
    checks++; if (drop_cnt !== 8'd3 || fifo_valid !== 1'b1) begin errors++; $display("FAIL en_setup: got drop=%0d v=%b want 3 1", drop_cnt, fifo_valid); end
    enable = 1'b0;
    step(1'b0, 8'h00);
    checks++; if (fifo_valid !== 1'b0 || drop_cnt !== 8'd0 || fifo_data !== 8'h00 || chk_valid !== 1'b0) begin errors++; $display("FAIL en_clear: got v=%b drop=%0d d=%h cv=%b want 0 0 00 0", fifo_valid, drop_cnt, fifo_data, chk_valid); end
    enable     = 1'b1;
    fifo_ready = 1'b1;
    step(1'b0, 8'h00);
    step(1'b1, 8'h9A);
    checks++; if (fifo_valid !== 1'b1 || fifo_data !== 8'h9A) begin errors++; $display("FAIL en_resume: got v=%b d=%h want 1 9a", fifo_valid, fifo_data); end
    step(1'b0, 8'h00);
  endtask

  task automatic test_async_reset();
    fifo_ready = 1'b0;
    step(1'b1, 8'hAB);
    rx_data_sel = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b1, 8'h00);
    checks++; if (rx_idle_det !== 1'b1 || fifo_valid !== 1'b1 || chk_valid !== 1'b1) begin errors++; $display("FAIL ar_setup: got idle=%b fv=%b cv=%b want 1 1 1", rx_idle_det, fifo_valid, chk_valid); end
    #5;
    rst_n = 1'b0;
    #1;
    checks++; if ({fifo_valid, chk_valid, rx_idle_det, fifo_data, chk_data, drop_cnt} !== 27'h0) begin errors++; $display("FAIL ar_clear: got %h want 0", {fifo_valid, chk_valid, rx_idle_det, fifo_data, chk_data, drop_cnt}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fifo_basic();
    test_idle();
    test_prbs();
    test_backpressure();
    test_mode_switch();
    test_drop_saturate();
    test_enable_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
